uart_receiver: RTL

- UART receiver, the receive-side counterpart of the team's UART transmitter. Same line format: 1 start bit, 8 data bits LSB first, stop bit(s). Same bit-period programming via `comp`.
- Sits between the asynchronous `uart_rx` pin and a byte-oriented consumer. Delivers each received byte through a valid/ack handshake and flags framing and overrun errors.

---
 rtl/uart_receiver.sv | 110 +++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with programmable bit period, valid/ack handoff and error pulses
module uart_receiver (
   input  logic        clk,
   input  logic        resetn,
   input  logic [15:0] comp,
   input  logic        rec_en,
   input  logic        uart_rx,
   input  logic        rx_ack,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        frame_err,
   output logic        overrun_err
);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t      state_q, state_d;
   logic        s1_q, rx_s_q, rx_d_q;
   logic [15:0] comp_int_q, comp_int_d, comp_c_q, comp_c_d;
   logic [2:0]  bit_c_q, bit_c_d;
   logic [7:0]  sh_q, sh_d, rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, overrun_err_q, overrun_err_d;
   logic        fall, hit;
   assign fall = rx_d_q & ~rx_s_q;
   assign hit  = comp_c_q == comp_int_q;
   always_comb begin
      state_d       = state_q;
      comp_int_d    = comp_int_q;
      comp_c_d      = comp_c_q + 16'd1;
      bit_c_d       = bit_c_q;
      sh_d          = sh_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q & ~rx_ack;
      frame_err_d   = 1'b0;
      overrun_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            comp_c_d = comp_c_q;
            if (fall) begin
               comp_int_d = comp;
               comp_c_d   = '0;
               state_d    = START;
            end
         end
         START: if (comp_c_q == comp_int_q >> 1) begin
            comp_c_d = '0;
            state_d  = rx_s_q ? IDLE : DATA;
         end
         DATA: if (hit) begin
            sh_d     = {rx_s_q, sh_q[7:1]};
            comp_c_d = '0;
            bit_c_d  = bit_c_q + 3'd1;
            state_d  = (bit_c_q == 3'd7) ? STOP : DATA;
         end
         STOP: if (hit) begin
            comp_c_d = '0;
            state_d  = IDLE;
            // a good byte may replace an unread one only when it is being acked this cycle
            if (rx_s_q && (!rx_valid_q || rx_ack)) begin
               rx_data_d  = sh_q;
               rx_valid_d = 1'b1;
            end
            overrun_err_d = rx_s_q & rx_valid_q & ~rx_ack;
            frame_err_d   = ~rx_s_q;
         end
         default: state_d = IDLE;
      endcase
      if (!rec_en) begin
         state_d       = IDLE;
         comp_c_d      = '0;
         bit_c_d       = '0;
         sh_d          = '0;
         rx_data_d     = '0;
         rx_valid_d    = 1'b0;
         frame_err_d   = 1'b0;
         overrun_err_d = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= IDLE;
         s1_q          <= 1'b1;
         rx_s_q        <= 1'b1;
         rx_d_q        <= 1'b1;
         comp_int_q    <= '0;
         comp_c_q      <= '0;
         bit_c_q       <= '0;
         sh_q          <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         s1_q          <= uart_rx;
         rx_s_q        <= s1_q;
         rx_d_q        <= rx_s_q;
         comp_int_q    <= comp_int_d;
         comp_c_q      <= comp_c_d;
         bit_c_q       <= bit_c_d;
         sh_q          <= sh_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         frame_err_q   <= frame_err_d;
         overrun_err_q <= overrun_err_d;
      end
   end
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_err_q;
endmodule
